// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: measures an incoming HSYNC/VSYNC pair against the expected mode,
// locks after consecutive good frames and regenerates HC/VC/VIDON one clock behind the source.
module vga_sync_decoder #(
    parameter int HPIXELS     = 800,
    parameter int VLINES      = 521,
    parameter int HSW         = 128,
    parameter int VSW         = 2,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        CLR_N,
    input  logic        HSYNC,
    input  logic        VSYNC,
    output logic [9:0]  HC,
    output logic [9:0]  VC,
    output logic        VIDON,
    output logic        LOCKED,
    output logic        ERR,
    output logic [10:0] LINE_LEN,
    output logic [9:0]  FRAME_LINES
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   good_cnt, good_nxt;
    logic            hs_prev, vs_prev;
    logic [10:0]     line_cnt;
    logic [9:0]      vlow_cnt, frame_cnt, hc_nxt, vc_nxt;
    logic            frame_bad, hs_fall, hs_rise, vs_fall, vs_rise;
    logic            line_bad, width_bad, vsw_bad, timeout, frame_good;
    logic            err_nxt, vidon_nxt;

    assign hs_fall = hs_prev & ~HSYNC;
    assign hs_rise = ~hs_prev & HSYNC;
    assign vs_fall = vs_prev & ~VSYNC;
    assign vs_rise = ~vs_prev & VSYNC;

    // line_cnt restarts at each hs_fall, so line_cnt+1 is both the low width at hs_rise and the line length at hs_fall
    assign line_bad   = hs_fall && (line_cnt + 11'd1 != 11'(HPIXELS));
    assign width_bad  = hs_rise && (line_cnt + 11'd1 != 11'(HSW));
    assign vsw_bad    = vs_rise && (vlow_cnt != 10'(VSW));
    assign timeout    = !hs_fall && (line_cnt == 11'(2 * HPIXELS));
    // the hs_fall coinciding with vs_fall closes the last line of the frame being judged
    assign frame_good = (frame_cnt == 10'(VLINES)) && !frame_bad && !line_bad;

    assign hc_nxt = hs_fall ? 10'd0 : (HC == '1 ? HC : HC + 10'd1);
    assign vc_nxt = vs_fall ? 10'd0 : (hs_fall && VC != '1) ? VC + 10'd1 : VC;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= S_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        if (timeout) begin
            state_nxt = S_SEARCH;
            good_nxt  = '0;
        end else if (vs_fall) begin
            case (state)
                S_SEARCH: begin
                    state_nxt = S_TRACK;
                    good_nxt  = '0;
                end
                S_TRACK: begin
                    good_nxt = frame_good ? good_cnt + GW'(1) : '0;
                    if (frame_good && good_cnt + GW'(1) == GW'(LOCK_FRAMES))
                        state_nxt = S_LOCKED;
                end
                default: begin
                    if (!frame_good) begin
                        state_nxt = S_TRACK;
                        good_nxt  = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        err_nxt   = (state == S_LOCKED) && (timeout || (vs_fall && !frame_good));
        vidon_nxt = (state_nxt == S_LOCKED) && hc_nxt >= 10'(HBP) && hc_nxt < 10'(HFP)
                    && vc_nxt >= 10'(VBP) && vc_nxt < 10'(VFP);
    end

    assign LOCKED = (state == S_LOCKED);

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            line_cnt    <= '0;
            vlow_cnt    <= '0;
            frame_cnt   <= '0;
            frame_bad   <= 1'b0;
            HC          <= '0;
            VC          <= '0;
            VIDON       <= 1'b0;
            ERR         <= 1'b0;
            LINE_LEN    <= '0;
            FRAME_LINES <= '0;
        end else begin
            hs_prev   <= HSYNC;
            vs_prev   <= VSYNC;
            line_cnt  <= hs_fall ? 11'd0 : (line_cnt == '1 ? line_cnt : line_cnt + 11'd1);
            vlow_cnt  <= vs_fall ? {9'd0, hs_fall}
                       : (hs_fall && !VSYNC && vlow_cnt != '1) ? vlow_cnt + 10'd1 : vlow_cnt;
            frame_cnt <= vs_fall ? {9'd0, hs_fall}
                       : (hs_fall && frame_cnt != '1) ? frame_cnt + 10'd1 : frame_cnt;
            frame_bad <= (timeout || vs_fall) ? 1'b0 : frame_bad | line_bad | width_bad | vsw_bad;
            HC        <= hc_nxt;
            VC        <= vc_nxt;
            VIDON     <= vidon_nxt;
            ERR       <= err_nxt;
            if (hs_fall)
                LINE_LEN <= line_cnt + 11'd1;
            if (vs_fall)
                FRAME_LINES <= frame_cnt;
        end
    end
endmodule
